// File: rtl/param_shift_rotate_unit.sv
// Universal shift/rotate register with a start/busy/done handshake.
// The unit executes a multi-bit shift amount serially, one bit position per clock.
// Every output is either a register or a decode of the state register.
module param_shift_rotate_unit #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             last_out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             last_q, last_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;

  logic [WIDTH-1:0] step_val;
  logic             step_last;
  logic [AMT_W-1:0] amt_clamped;

  // Amounts above WIDTH are clamped to WIDTH.
  assign amt_clamped = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;

  // Compute the result of one single-bit step of the latched operation.
  always_comb begin
    step_val  = q_q;
    step_last = last_q;
    case (op_q)
      3'b000: begin  // ROL
        step_val  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_last = q_q[WIDTH-1];
      end
      3'b001: begin  // ROR
        step_val  = {q_q[0], q_q[WIDTH-1:1]};
        step_last = q_q[0];
      end
      3'b010: begin  // LSL
        step_val  = {q_q[WIDTH-2:0], 1'b0};
        step_last = q_q[WIDTH-1];
      end
      3'b011: begin  // LSR
        step_val  = {1'b0, q_q[WIDTH-1:1]};
        step_last = q_q[0];
      end
      3'b100: begin  // ASR
        step_val  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_last = q_q[0];
      end
      3'b101: begin  // SSL
        step_val  = {q_q[WIDTH-2:0], serial_in};
        step_last = q_q[WIDTH-1];
      end
      3'b110: begin  // SSR
        step_val  = {serial_in, q_q[WIDTH-1:1]};
        step_last = q_q[0];
      end
      default: begin  // HOLD: data untouched, but it still counts through the steps
        step_val  = q_q;
        step_last = last_q;
      end
    endcase
  end

  // Next-state logic for the IDLE/SHIFT/DONE sequencer and the datapath.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    last_d  = last_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          q_d = data_in;
        end else if (start) begin
          op_d    = op;
          count_d = amt_clamped;
          state_d = (amt_clamped == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        q_d     = step_val;
        last_d  = step_last;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      q_q     <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      last_q  <= last_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign q        = q_q;
  assign last_out = last_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: doc/param_shift_rotate_unit.md
Name: param_shift_rotate_unit

Overview:
Parametrised universal shift/rotate register with a start/busy/done handshake. It generalises the 8-bit rotate/arithmetic-shift register to WIDTH bits and eight operations. It also takes a multi-bit shift amount, which it executes serially at one bit position per clock. It sits between the switch/key input logic and the LED/display logic, and is also used as a serial-in/serial-out datapath element.

Parameters:
WIDTH, 8, register width in bits; minimum 2.
AMT_W, $clog2(WIDTH+1), width of the amount port; derived, never overridden.

Ports:
clk  in  1  rising-edge clock
resetn  in  1  reset, synchronous, active-low
data_in  in  WIDTH  parallel load value
load  in  1  parallel load request; honoured in IDLE only
start  in  1  operation request; honoured in IDLE only
op  in  3  operation code, latched at start
amount  in  AMT_W  number of single-bit steps, latched at start
serial_in  in  1  fill bit for op SSL/SSR, sampled on every shift edge
q  out  WIDTH  register contents
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle completion pulse
last_out  out  1  bit most recently shifted or rotated out

Behaviour:
- Reset: when resetn=0 at a clk edge, the next state is:
  - q=0, last_out=0, busy=0, done=0;
  - state=IDLE, step counter=0.
- Reset overrides everything, including a shift in progress. No partial result is retained.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1: q<=data_in; start is ignored that cycle (load has priority).
  - else start=1: latch op and amt = min(amount, WIDTH).
    - amt=0: go to DONE; q unchanged.
    - amt>0: go to SHIFT with count<=amt.
  - otherwise hold.
- SHIFT:
  - Each edge performs one single-bit step on q and updates last_out with the bit that left q; count decrements.
  - The edge where count==1 does the final step and goes to DONE.
  - load and start are ignored throughout.
- DONE: done=1 for exactly this one cycle. The next edge goes to IDLE. load and start are ignored.
- Timing: with start sampled at edge E0, steps occur at edges E1..En (n=amt). done is high in the cycle after En; for amt=0, in the cycle after E0. busy is high from after E0 through the DONE cycle, i.e. n+1 cycles.
- op encoding, one step each:
  - 000 ROL: q<={q[W-2:0],q[W-1]}; last_out<=q[W-1].
  - 001 ROR: q<={q[0],q[W-1:1]}; last_out<=q[0].
  - 010 LSL: zero fill at LSB; last_out<=q[W-1].
  - 011 LSR: zero fill at MSB; last_out<=q[0].
  - 100 ASR: MSB replicated; last_out<=q[0].
  - 101 SSL: serial_in fills LSB; last_out<=q[W-1].
  - 110 SSR: serial_in fills MSB; last_out<=q[0].
  - 111 HOLD: q and last_out unchanged, but counts and handshakes exactly as the other ops.
- Boundaries:
  - Amounts greater than WIDTH clamp to WIDTH. Example: WIDTH=8, amount=15 gives 8 steps.
  - ROL/ROR by WIDTH returns the original value.
  - LSL/LSR by WIDTH gives 0.
  - ASR by WIDTH gives all copies of the original MSB.
  - Changes to op or amount after the start edge have no effect.
  - A start held high continuously re-triggers only on returning to IDLE, i.e. once every n+2 cycles.
- No combinational path from inputs to outputs. All outputs are registered or decoded from state.

Test Plan:
1. resetn=0 for 2 edges with random inputs → q=0x00, busy=0, done=0, last_out=0.
2. WIDTH=8: load 0xB1, then start op=ROR amount=3 → q steps D8, 6C, 36; done pulses once in the 4th cycle after start; busy high 4 cycles; final last_out=0.
3. Load 0x90, start op=ASR amount=15 → clamps to 8 steps, q=0xFF, last_out=1, done in the 9th cycle after start.
4. Load 0x5A, start op=LSL amount=0 → q stays 0x5A, busy=1 and done=1 for exactly one cycle.
5. Load 0x81, start op=ROL amount=5; drive resetn=0 after 2 steps (q=0x06) → next edge q=0, busy=0, no done pulse; later ops behave normally.
6. Handshake priority and serial fill:
   - load 0x00, then start SSL amount=4 with serial_in=1 → q=0x0F.
   - load=1 with data 0xAA during SHIFT → ignored.
   - load+start in the same IDLE cycle → q=data_in, no operation starts.
